// File: rtl/knn_pkg.sv
// Shared decode constants, FSM state encoding and distance-mode type for the k-NN PCPI accelerator.
package knn_pkg;

  localparam logic [6:0] KNN_OPCODE = 7'b0001011;
  localparam logic [2:0] KNN_FUNCT3 = 3'b000;
  localparam logic [6:0] KNN_F7_L2  = 7'b0000001;
  localparam logic [6:0] KNN_F7_L1  = 7'b0000010;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_WT_A = 3'd2,
    ST_RD_B = 3'd3,
    ST_WT_B = 3'd4,
    ST_DONE = 3'd5,
    ST_HOLD = 3'd6
  } knn_state_e;

  typedef enum logic {
    DIST_L2 = 1'b0,
    DIST_L1 = 1'b1
  } dist_mode_e;

endpackage

// File: rtl/knn_pcpi_accel_if.sv
// PCPI instruction port plus the private memory read port of the k-NN accelerator.
interface knn_pcpi_accel_if;

  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  logic        mem_valid;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, mem_ready, mem_rdata,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
    output mem_valid, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, mem_ready, mem_rdata,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
    input  mem_valid, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/knn_dist_term.sv
// Per-pixel distance term: squared difference (L2) or absolute difference (L1) of two 8-bit pixels.
module knn_dist_term
  import knn_pkg::*;
(
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  input  dist_mode_e  i_mode,
  output logic [16:0] o_term
);

  logic [8:0]  w_diff;
  logic [7:0]  w_abs;
  logic [15:0] w_sq;

  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  // |diff| never exceeds 255, so the magnitude fits in 8 bits
  assign w_abs  = w_diff[8] ? 8'(9'd0 - w_diff) : w_diff[7:0];
  assign w_sq   = {8'd0, w_abs} * {8'd0, w_abs};

  assign o_term = (i_mode == DIST_L1) ? {9'd0, w_abs} : {1'b0, w_sq};

endmodule

// File: rtl/knn_pcpi_accel.sv
// k-NN distance PCPI coprocessor: reads two image records and returns their L2 (or L1) distance.
// Optional L1 mode is enabled by defining KNN_L1_DIST_EN.
module knn_pcpi_accel
  import knn_pkg::*;
#(
  parameter int N_PIXELS  = 3072,
  parameter int HDR_WORDS = 1
) (
  input  logic            clk,
  input  logic            resetn,
  knn_pcpi_accel_if.slave bus
);

  // state   | meaning
  // IDLE    | waiting for a matching instruction
  // RD_A    | issue read of pixel i of record A
  // WT_A    | wait for record A data
  // RD_B    | issue read of pixel i of record B
  // WT_B    | wait for record B data, accumulate term
  // DONE    | present result for one cycle
  // HOLD    | let the CPU drop pcpi_valid
  knn_state_e  r_state, w_next;
  logic [31:0] r_base_a, r_base_b, r_acc, r_idx, r_rd;
  logic [7:0]  r_pix_a;
  dist_mode_e  r_mode, w_mode;
  logic        w_match, w_accept, w_last, w_unused;
  logic [16:0] w_term;
  logic [31:0] w_acc_next, w_word_off;

  always_comb begin
    w_match = 1'b0;
    w_mode  = DIST_L2;
    if (bus.pcpi_insn[6:0] == KNN_OPCODE && bus.pcpi_insn[14:12] == KNN_FUNCT3) begin
      if (bus.pcpi_insn[31:25] == KNN_F7_L2) begin
        w_match = 1'b1;
      end
`ifdef KNN_L1_DIST_EN
      else if (bus.pcpi_insn[31:25] == KNN_F7_L1) begin
        w_match = 1'b1;
        w_mode  = DIST_L1;
      end
`endif
    end
  end

  assign w_accept   = bus.pcpi_valid && w_match;
  assign w_last     = (r_idx == 32'(N_PIXELS - 1));
  assign w_acc_next = r_acc + {15'd0, w_term};
  assign w_word_off = (32'(HDR_WORDS) + r_idx) << 2;
  assign w_unused   = ^{bus.pcpi_insn[24:15], bus.pcpi_insn[11:7], bus.mem_rdata[31:8]};

  knn_dist_term u_term (
    .i_a    (r_pix_a),
    .i_b    (bus.mem_rdata[7:0]),
    .i_mode (r_mode),
    .o_term (w_term)
  );

  always_comb begin
    w_next          = r_state;
    bus.pcpi_wait   = 1'b0;
    bus.pcpi_ready  = 1'b0;
    bus.pcpi_wr     = 1'b0;
    bus.mem_valid   = 1'b0;
    bus.mem_addr    = 32'd0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          bus.pcpi_wait = 1'b1;
          w_next        = ST_RD_A;
        end
      end
      ST_RD_A: begin
        bus.pcpi_wait = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = r_base_a + w_word_off;
        w_next        = ST_WT_A;
      end
      ST_WT_A: begin
        bus.pcpi_wait = 1'b1;
        if (bus.mem_ready) w_next = ST_RD_B;
      end
      ST_RD_B: begin
        bus.pcpi_wait = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = r_base_b + w_word_off;
        w_next        = ST_WT_B;
      end
      ST_WT_B: begin
        bus.pcpi_wait = 1'b1;
        if (bus.mem_ready) w_next = w_last ? ST_DONE : ST_RD_A;
      end
      ST_DONE: begin
        bus.pcpi_ready = 1'b1;
        bus.pcpi_wr    = 1'b1;
        w_next         = ST_HOLD;
      end
      ST_HOLD: begin
        bus.pcpi_wait = 1'b1;
        w_next        = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_base_a <= 32'd0;
      r_base_b <= 32'd0;
      r_acc    <= 32'd0;
      r_idx    <= 32'd0;
      r_rd     <= 32'd0;
      r_pix_a  <= 8'd0;
      r_mode   <= DIST_L2;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_base_a <= bus.pcpi_rs1;
            r_base_b <= bus.pcpi_rs2;
            r_acc    <= 32'd0;
            r_idx    <= 32'd0;
            r_mode   <= w_mode;
          end
        end
        ST_WT_A: if (bus.mem_ready) r_pix_a <= bus.mem_rdata[7:0];
        ST_WT_B: begin
          if (bus.mem_ready) begin
            r_acc <= w_acc_next;
            r_idx <= r_idx + 32'd1;
            // result register keeps the last distance between instructions
            if (w_last) r_rd <= w_acc_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pcpi_rd   = r_rd;
  assign bus.mem_write = 1'b0;
  assign bus.mem_wdata = 32'd0;

endmodule

// File: tb/tb_knn_pcpi_accel.sv
// Directed bench for knn_pcpi_accel: a 4-pixel instance and a default 3072-pixel instance.
module tb_knn_pcpi_accel;

  localparam logic [31:0] INSN_L2  = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0001011};
  localparam logic [31:0] INSN_L1  = {7'b0000010, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0001011};
  localparam logic [31:0] INSN_F3  = {7'b0000011, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0001011};
  localparam logic [31:0] INSN_MUL = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  knn_pcpi_accel_if if_s ();
  knn_pcpi_accel_if if_b ();

  knn_pcpi_accel #(.N_PIXELS(4), .HDR_WORDS(1)) u_small (.clk(clk), .resetn(resetn), .bus(if_s));
  knn_pcpi_accel u_big (.clk(clk), .resetn(resetn), .bus(if_b));

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // shared sparse memory; absent words read as 0
  logic [31:0] mem [logic [31:0]];
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  always @(posedge clk) begin
    if_s.mem_ready <= if_s.mem_valid;
    if_s.mem_rdata <= if_s.mem_valid ? mem_rd(if_s.mem_addr) : 32'h0;
    if_b.mem_ready <= if_b.mem_valid;
    if_b.mem_rdata <= if_b.mem_valid ? mem_rd(if_b.mem_addr) : 32'h0;
  end

  int rdy_cnt_s = 0, rdy_cnt_b = 0, memv_cnt_s = 0, held_errs = 0, wr_errs = 0;
  logic prev_mv_s = 0, prev_mv_b = 0, prev_rdy_s = 0, prev_rdy_b = 0;
  logic [31:0] addr_q[$];

  always @(negedge clk) begin
    if (if_s.pcpi_ready) rdy_cnt_s++;
    if (if_b.pcpi_ready) rdy_cnt_b++;
    if (if_s.mem_valid) begin
      memv_cnt_s++;
      addr_q.push_back(if_s.mem_addr);
    end
    if ((if_s.mem_valid && prev_mv_s) || (if_b.mem_valid && prev_mv_b)) held_errs++;
    if ((if_s.pcpi_ready && prev_rdy_s) || (if_b.pcpi_ready && prev_rdy_b)) held_errs++;
    if (if_s.mem_write || if_b.mem_write || if_s.mem_wdata != 0 || if_b.mem_wdata != 0) wr_errs++;
    prev_mv_s  = if_s.mem_valid;
    prev_mv_b  = if_b.mem_valid;
    prev_rdy_s = if_s.pcpi_ready;
    prev_rdy_b = if_b.pcpi_ready;
  end

  logic sel_big = 1'b0;
  wire        w_rdy_sel  = sel_big ? if_b.pcpi_ready : if_s.pcpi_ready;
  wire        w_wait_sel = sel_big ? if_b.pcpi_wait  : if_s.pcpi_wait;
  wire        w_wr_sel   = sel_big ? if_b.pcpi_wr    : if_s.pcpi_wr;
  wire [31:0] w_rd_sel   = sel_big ? if_b.pcpi_rd    : if_s.pcpi_rd;

  task automatic drive(input bit big, input logic v, input logic [31:0] insn,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    if (big) begin
      if_b.pcpi_valid = v; if_b.pcpi_insn = insn; if_b.pcpi_rs1 = rs1; if_b.pcpi_rs2 = rs2;
    end else begin
      if_s.pcpi_valid = v; if_s.pcpi_insn = insn; if_s.pcpi_rs1 = rs1; if_s.pcpi_rs2 = rs2;
    end
  endtask

  task automatic run_insn(input string tag, input bit big, input logic [31:0] insn,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] exp_rd, input int exp_lat);
    int  lat;
    bit  got;
    lat = 0;
    got = 1'b0;
    sel_big = big;
    @(negedge clk);
    drive(big, 1'b1, insn, rs1, rs2);
    #1 chk({tag, "_wait_accept"}, 32'(w_wait_sel), 32'd1);
    @(posedge clk);
    while (!got && lat < exp_lat + 20) begin
      @(negedge clk);
      lat++;
      if (w_rdy_sel) got = 1'b1;
    end
    chk({tag, "_ready_seen"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rd"}, w_rd_sel, exp_rd);
    chk({tag, "_wr"}, 32'(w_wr_sel), 32'd1);
    drive(big, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk({tag, "_hold_ready"}, 32'(w_rdy_sel), 32'd0);
    chk({tag, "_hold_wait"}, 32'(w_wait_sel), 32'd1);
    chk({tag, "_rd_held"}, w_rd_sel, exp_rd);
    @(negedge clk);
    chk({tag, "_idle_wait"}, 32'(w_wait_sel), 32'd0);
  endtask

  task automatic ignore_insn(input string tag, input logic [31:0] insn);
    int mv0, r0, bad;
    mv0 = memv_cnt_s;
    r0  = rdy_cnt_s;
    bad = 0;
    sel_big = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, insn, 32'h10000, 32'h1C004);
    for (int k = 0; k < 6; k++) begin
      #1 if (if_s.pcpi_wait || if_s.pcpi_ready) bad++;
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    chk({tag, "_wait_ready_low"}, 32'(bad), 32'd0);
    chk({tag, "_no_mem"}, 32'(memv_cnt_s - mv0), 32'd0);
    chk({tag, "_no_ready"}, 32'(rdy_cnt_s - r0), 32'd0);
  endtask

  int r0, bad;
  int exp_rdy_s;

  initial begin
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    // record A at 0x10000 (label + 4 pixels), record B at 0x1C004; upper bytes are noise
    mem[32'h10000] = 32'h000000FF;
    mem[32'h10004] = 32'hAB000000;
    mem[32'h10008] = 32'h1234560A;
    mem[32'h1000C] = 32'hFFFFFFFF;
    mem[32'h10010] = 32'h00000007;
    mem[32'h1C004] = 32'h00000003;
    mem[32'h1C008] = 32'h55555500;
    mem[32'h1C00C] = 32'h0000000D;
    mem[32'h1C010] = 32'h12345600;
    mem[32'h1C014] = 32'h87654307;
    mem[32'h20000] = 32'h00000009;
    mem[32'h20004] = 32'h1234567F;
    mem[32'h100000] = 32'h000000FF;
    for (int i = 0; i < 3072; i++) mem[32'h100004 + 32'(4 * i)] = {i[23:0], 8'hFF};

    repeat (4) @(negedge clk);
    chk("rst_wait", 32'(if_s.pcpi_wait), 32'd0);
    chk("rst_ready", 32'(if_s.pcpi_ready), 32'd0);
    chk("rst_wr", 32'(if_s.pcpi_wr), 32'd0);
    chk("rst_rd", if_s.pcpi_rd, 32'd0);
    chk("rst_mem_valid", 32'(if_s.mem_valid), 32'd0);
    chk("rst_mem_addr", if_s.mem_addr, 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    addr_q.delete();
    run_insn("l2_small", 1'b0, INSN_L2, 32'h10000, 32'h1C004, 32'd65034, 17);
    chk("addr_count", 32'(addr_q.size()), 32'd8);
    if (addr_q.size() == 8) begin
      chk("addr_first_a", addr_q[0], 32'h10004);
      chk("addr_first_b", addr_q[1], 32'h1C008);
      chk("addr_last_a", addr_q[6], 32'h10010);
      chk("addr_last_b", addr_q[7], 32'h1C014);
    end

    run_insn("pix_mask", 1'b0, INSN_L2, 32'h20000, 32'h30000, 32'd16129, 17);

    ignore_insn("funct7_3", INSN_F3);
    ignore_insn("opcode_mul", INSN_MUL);
`ifdef KNN_L1_DIST_EN
    run_insn("l1_small", 1'b0, INSN_L1, 32'h10000, 32'h1C004, 32'd258, 17);
    exp_rdy_s = 4;
`else
    ignore_insn("funct7_2", INSN_L1);
    exp_rdy_s = 3;
`endif

    // abort a run with a 5-cycle reset; no result may appear
    sel_big = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, INSN_L2, 32'h10000, 32'h1C004);
    repeat (10) @(negedge clk);
    r0 = rdy_cnt_s;
    resetn = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (if_s.pcpi_wait || if_s.pcpi_ready || if_s.pcpi_wr || if_s.mem_valid ||
          if_s.pcpi_rd != 0 || if_s.mem_addr != 0) bad++;
    end
    chk("midrst_outputs_zero", 32'(bad), 32'd0);
    chk("midrst_rd", if_s.pcpi_rd, 32'd0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_ready", 32'(rdy_cnt_s - r0), 32'd0);
    run_insn("after_rst", 1'b0, INSN_L2, 32'h10000, 32'h1C004, 32'd65034, 17);

    run_insn("l2_big", 1'b1, INSN_L2, 32'h100000, 32'h200000, 32'd199756800, 12289);

    chk("ready_count_small", 32'(rdy_cnt_s), 32'(exp_rdy_s));
    chk("ready_count_big", 32'(rdy_cnt_b), 32'd1);
    chk("no_held_pulses", 32'(held_errs), 32'd0);
    chk("no_mem_writes", 32'(wr_errs), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
